// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: sequencing control unit for the single-precision FP adder datapath.
// One addition per start pulse: IDLE -> ALIGN -> NORM -> CHECK -> [RENORM] -> DONE.
// All outputs are registered and depend only on state and internal registers.
// Optional feature macro: FP_ADD_CTRL_ZERO_BYPASS_EN. When it is defined, a zero
// magnitude seen in ALIGN skips CHECK and asserts zero with done.
module fp_add_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [26:0] ula,
    input  logic [26:0] round_fract,
    output logic        sinalMuxFP1,
    output logic        sinalMuxFP2,
    output logic        sinalMuxFP3,
    output logic        sinalMuxFP4,
    output logic        sinalMuxFP5,
    output logic [7:0]  sinalShiftFract,
    output logic [8:0]  sinalShiftRes,
    output logic [8:0]  sinalIncOrDec,
    output logic        sinalRound,
    output logic        busy,
    output logic        done,
    output logic        zero
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_NORM   = 3'd2,
        S_CHECK  = 3'd3,
        S_RENORM = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t     state_reg;
    logic       renorm_reg;
    logic       a_ge_b_next;
    logic [7:0] dif_next;
    logic [7:0] lz_next;
    logic [7:0] norm_amt_next;
    logic       ula_zero;
    logic       unused_round_bits;

    // Only the carry-out bit of the rounding register steers the sequence.
    assign unused_round_bits = ^round_fract[25:0];

    // Operand ordering and exponent difference, captured when start is accepted.
    assign a_ge_b_next = (exp_a >= exp_b);
    assign dif_next    = a_ge_b_next ? (exp_a - exp_b) : (exp_b - exp_a);
    assign ula_zero    = (ula == 27'd0);

    // Leading-zero count of the adder magnitude; an all-zero magnitude yields 26.
    always_comb begin
        lz_next = 8'd26;
        for (int i = 0; i < 27; i++) begin
            if (ula[i]) begin
                lz_next = 8'(26 - i);
            end
        end
    end

`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
    logic zero_reg;

    // A zero result needs no shifting: the direction bit is kept, the amount is 0.
    assign norm_amt_next = ula_zero ? 8'd0 : lz_next;
`else
    assign norm_amt_next = lz_next;
    assign zero          = 1'b0;
`endif

    // Control FSM; the select/shift output registers also hold a_ge_b, dif and lz.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            renorm_reg      <= 1'b0;
            sinalMuxFP1     <= 1'b0;
            sinalMuxFP2     <= 1'b0;
            sinalMuxFP3     <= 1'b0;
            sinalMuxFP4     <= 1'b0;
            sinalMuxFP5     <= 1'b0;
            sinalShiftFract <= 8'd0;
            sinalShiftRes   <= 9'd0;
            sinalIncOrDec   <= 9'd0;
            sinalRound      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
            zero_reg        <= 1'b0;
            zero            <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sinalMuxFP1     <= ~a_ge_b_next;
                        sinalMuxFP2     <= ~a_ge_b_next;
                        sinalMuxFP3     <= a_ge_b_next;
                        sinalMuxFP4     <= 1'b0;
                        sinalMuxFP5     <= 1'b0;
                        sinalShiftFract <= dif_next;
                        busy            <= 1'b1;
                        state_reg       <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    sinalShiftRes <= {1'b1, norm_amt_next};
                    sinalIncOrDec <= {1'b1, norm_amt_next};
                    sinalRound    <= 1'b1;
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
                    zero_reg      <= ula_zero;
`endif
                    state_reg     <= S_NORM;
                end
                S_NORM: begin
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
                    if (zero_reg) begin
                        done      <= 1'b1;
                        zero      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_CHECK;
                    end
`else
                    state_reg <= S_CHECK;
`endif
                end
                S_CHECK: begin
                    if (round_fract[26] && !renorm_reg) begin
                        sinalMuxFP4   <= 1'b1;
                        sinalMuxFP5   <= 1'b1;
                        sinalShiftRes <= 9'h001;
                        sinalIncOrDec <= 9'h001;
                        sinalRound    <= 1'b1;
                        state_reg     <= S_RENORM;
                    end else begin
                        done      <= 1'b1;
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
                        zero      <= zero_reg;
`endif
                        state_reg <= S_DONE;
                    end
                end
                S_RENORM: begin
                    renorm_reg    <= 1'b1;
                    sinalShiftRes <= 9'd0;
                    sinalIncOrDec <= 9'd0;
                    sinalRound    <= 1'b0;
                    done          <= 1'b1;
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
                    zero          <= zero_reg;
`endif
                    state_reg     <= S_DONE;
                end
                S_DONE: begin
                    renorm_reg      <= 1'b0;
                    sinalMuxFP1     <= 1'b0;
                    sinalMuxFP2     <= 1'b0;
                    sinalMuxFP3     <= 1'b0;
                    sinalMuxFP4     <= 1'b0;
                    sinalMuxFP5     <= 1'b0;
                    sinalShiftFract <= 8'd0;
                    sinalShiftRes   <= 9'd0;
                    sinalIncOrDec   <= 9'd0;
                    sinalRound      <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
                    zero_reg        <= 1'b0;
                    zero            <= 1'b0;
`endif
                    state_reg       <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_ctrl.sv
// tb_fp_add_ctrl: directed vectors for fp_add_ctrl with a queue-based scoreboard.
// Stimulus pushes the expected per-operation response; a negedge monitor traces
// each operation from busy rising to done and compares against the queue head.
module tb_fp_add_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  exp_a = 8'd0;
    logic [7:0]  exp_b = 8'd0;
    logic [26:0] ula = 27'd0;
    logic [26:0] round_fract = 27'd0;
    logic        sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5;
    logic [7:0]  sinalShiftFract;
    logic [8:0]  sinalShiftRes, sinalIncOrDec;
    logic        sinalRound, busy, done, zero;

    fp_add_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .exp_a          (exp_a),
        .exp_b          (exp_b),
        .ula            (ula),
        .round_fract    (round_fract),
        .sinalMuxFP1    (sinalMuxFP1),
        .sinalMuxFP2    (sinalMuxFP2),
        .sinalMuxFP3    (sinalMuxFP3),
        .sinalMuxFP4    (sinalMuxFP4),
        .sinalMuxFP5    (sinalMuxFP5),
        .sinalShiftFract(sinalShiftFract),
        .sinalShiftRes  (sinalShiftRes),
        .sinalIncOrDec  (sinalIncOrDec),
        .sinalRound     (sinalRound),
        .busy           (busy),
        .done           (done),
        .zero           (zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] mux123;
        logic [7:0] sf;
        logic [8:0] nres;
        int         lat;
        logic       renorm;
        logic       zro;
        logic [8:0] done_sr;
        logic       done_round;
        logic [1:0] done_m45;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    // monitor trace registers
    int         idx = 0;
    logic [2:0] c_mux;
    logic [7:0] c_sf;
    logic [1:0] c_m45a;
    logic [8:0] c_nres, c_ninc, c_rres, c_rinc;
    logic       c_nround;
    logic [1:0] c_rm45;
    exp_t       e_mon;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] mux123, input logic [7:0] sf,
                                input logic [8:0] nres, input int lat,
                                input logic renorm, input logic zro);
        exp_t e;
        e.mux123     = mux123;
        e.sf         = sf;
        e.nres       = nres;
        e.lat        = lat;
        e.renorm     = renorm;
        e.zro        = zro;
        e.done_sr    = renorm ? 9'd0 : nres;
        e.done_round = renorm ? 1'b0 : 1'b1;
        e.done_m45   = renorm ? 2'b11 : 2'b00;
        return e;
    endfunction

    function automatic logic [63:0] all_outs();
        return {29'd0, sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5,
                sinalShiftFract, sinalShiftRes, sinalIncOrDec, sinalRound, busy, done, zero};
    endfunction

    // Monitor: trace one operation per busy window and score it at done.
    initial begin
        forever begin
            @(negedge clock);
            if (reset || !busy) begin
                idx = 0;
            end else begin
                idx++;
                if (idx == 1) begin
                    c_mux  = {sinalMuxFP1, sinalMuxFP2, sinalMuxFP3};
                    c_sf   = sinalShiftFract;
                    c_m45a = {sinalMuxFP4, sinalMuxFP5};
                end
                if (idx == 2) begin
                    c_nres   = sinalShiftRes;
                    c_ninc   = sinalIncOrDec;
                    c_nround = sinalRound;
                end
                if (idx == 4 && !done) begin
                    c_rres = sinalShiftRes;
                    c_rinc = sinalIncOrDec;
                    c_rm45 = {sinalMuxFP4, sinalMuxFP5};
                end
                if (done) begin
                    done_cnt++;
                    check("expected_op_pending", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        e_mon = sb_q.pop_front();
                        check("align_mux123", 64'(c_mux), 64'(e_mon.mux123));
                        check("align_shift_fract", 64'(c_sf), 64'(e_mon.sf));
                        check("align_mux45", 64'(c_m45a), 64'd0);
                        check("norm_shift_res", 64'(c_nres), 64'(e_mon.nres));
                        check("norm_inc_dec", 64'(c_ninc), 64'(e_mon.nres));
                        check("norm_round", 64'(c_nround), 64'd1);
                        check("latency", 64'(idx), 64'(e_mon.lat));
                        check("zero", 64'(zero), 64'(e_mon.zro));
                        check("done_shift_res", 64'(sinalShiftRes), 64'(e_mon.done_sr));
                        check("done_inc_dec", 64'(sinalIncOrDec), 64'(e_mon.done_sr));
                        check("done_round", 64'(sinalRound), 64'(e_mon.done_round));
                        check("done_mux45", 64'({sinalMuxFP4, sinalMuxFP5}), 64'(e_mon.done_m45));
                        if (e_mon.renorm) begin
                            check("renorm_shift_res", 64'(c_rres), 64'h001);
                            check("renorm_inc_dec", 64'(c_rinc), 64'h001);
                            check("renorm_mux45", 64'(c_rm45), 64'd3);
                        end
                        $display("op: mux123=%b sf=%0d norm_res=%h lat=%0d zero=%b",
                                 c_mux, c_sf, c_nres, idx, zero);
                    end
                    idx = 0;
                end
            end
        end
    end

    // Issue one operation; optionally keep start high for the whole busy window.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [26:0] u, input logic [26:0] rf,
                          input exp_t e, input bit extra);
        int k;
        @(posedge clock); #1;
        exp_a = a; exp_b = b; ula = u; round_fract = rf; start = 1'b1;
        sb_q.push_back(e);
        @(posedge clock); #1;
        start = extra;
        if (extra) begin
            repeat (e.lat) @(posedge clock);
            #1;
            start = 1'b0;
        end
        k = 0;
        while (busy && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("op_finished", 64'(busy), 64'd0);
    endtask

    initial begin
        int dc;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs_held", all_outs(), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_outputs", all_outs(), 64'd0);

        run_op(8'd130, 8'd127, 27'h4000000, 27'd0, mk(3'b001, 8'd3,   9'h100, 4, 1'b0, 1'b0), 1'b0);
        run_op(8'd100, 8'd140, 27'h0100000, 27'd0, mk(3'b110, 8'd40,  9'h106, 4, 1'b0, 1'b0), 1'b0);
        run_op(8'd127, 8'd127, 27'h0000001, 27'd0, mk(3'b001, 8'd0,   9'h11A, 4, 1'b0, 1'b0), 1'b0);
        run_op(8'd255, 8'd0,   27'h0000800, 27'd0, mk(3'b001, 8'd255, 9'h10F, 4, 1'b0, 1'b0), 1'b0);
        run_op(8'd0,   8'd255, 27'h0000800, 27'd0, mk(3'b110, 8'd255, 9'h10F, 4, 1'b0, 1'b0), 1'b0);
        // Rounding carry held high throughout: exactly one RENORM, start ignored while busy.
        run_op(8'd127, 8'd120, 27'h2000000, 27'h4000000, mk(3'b001, 8'd7, 9'h101, 5, 1'b1, 1'b0), 1'b1);
        // start held through a plain operation including its DONE cycle.
        run_op(8'd90,  8'd91,  27'h0100000, 27'd0, mk(3'b110, 8'd1,   9'h106, 4, 1'b0, 1'b0), 1'b1);
`ifdef FP_ADD_CTRL_ZERO_BYPASS_EN
        run_op(8'd5, 8'd200, 27'd0, 27'd0, mk(3'b110, 8'd195, 9'h100, 3, 1'b0, 1'b1), 1'b0);
`else
        run_op(8'd5, 8'd200, 27'd0, 27'd0, mk(3'b110, 8'd195, 9'h11A, 4, 1'b0, 1'b0), 1'b0);
`endif

        // Reset in NORM: back to IDLE, all outputs 0, no done.
        dc = done_cnt;
        @(posedge clock); #1;
        exp_a = 8'd140; exp_b = 8'd130; ula = 27'h0100000; round_fract = 27'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_mid_op_outputs", all_outs(), 64'd0);
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("reset_mid_op_no_done", 64'(done_cnt), 64'(dc));
        check("reset_mid_op_idle", all_outs(), 64'd0);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
